// File: rtl/i2c_seq_pkg.sv
// Shared constants for the I2C configuration sequencer: FSM encodings,
// the end-of-table sentinel and the delay counter width.
package i2c_seq_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_ISSUE   = 3'd2;
    localparam logic [2:0] ST_WAIT_LO = 3'd3;
    localparam logic [2:0] ST_WAIT_HI = 3'd4;
    localparam logic [2:0] ST_SETTLE  = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;
    localparam logic [2:0] ST_ERROR   = 3'd7;

    localparam logic [15:0] SENTINEL = 16'hFFFF;

    // Wide enough for multi-second timeouts at 50 MHz
    localparam int CNT_W = 32;

    function automatic logic isSentinel(input logic [15:0] word);
        return word == SENTINEL;
    endfunction

endpackage

// File: rtl/i2c_seq_delay.sv
// Loadable down-counter with a terminal flag; one instance serves both the
// inter-write settle delay and the per-phase controller timeouts.
module i2c_seq_delay #(
    parameter int W = 32
) (
    input  logic         clk_in,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] loadVal_i,
    output logic         expired_o
);

    logic [W-1:0] count_q;

    // Counts down to zero and parks there until reloaded
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= loadVal_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks a ROM table of {reg_addr, reg_data} words and issues one I2C write
// per entry. Optional NACK retry is built only with `define I2C_SEQ_RETRY_EN.
module i2c_config_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int          NUM_REGS       = 16,
    parameter logic [7:0]  DEV_ADDR       = 8'h34,
    parameter int          SETTLE_CYCLES  = 50000,
    parameter int          TIMEOUT_CYCLES = 2000000,
`ifdef I2C_SEQ_RETRY_EN
    parameter int          RETRY_MAX      = 3,
`endif
    parameter int          IDX_W          = 8
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             go,
    output logic [IDX_W-1:0] rom_addr,
    input  logic [15:0]      rom_data,
    output logic             i2c_start,
    output logic [7:0]       i2c_dev_addr,
    output logic [15:0]      i2c_reg_data,
    input  logic             i2c_ready,
    input  logic             i2c_ack,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [IDX_W-1:0] err_idx,
    output logic [2:0]       state_dbg
);

    // The counter reads zero on the last cycle of a phase, hence the -1
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W:0]   IDX_END      = (IDX_W + 1)'(NUM_REGS);

    logic [2:0]       state_q,   state_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic [15:0]      regData_q, regData_d;
    logic             start_q,   start_d;
    logic [IDX_W-1:0] errIdx_q,  errIdx_d;
    logic             fetchPh_q, fetchPh_d;
    logic             dlyLoad;
    logic [CNT_W-1:0] dlyVal;
    logic             dlyExpired;
    logic [IDX_W:0]   idxNext;

`ifdef I2C_SEQ_RETRY_EN
    localparam logic [7:0] RETRY_LIMIT = 8'(RETRY_MAX);
    logic [7:0] retryCnt_q, retryCnt_d;
`endif

    i2c_seq_delay #(
        .W (CNT_W)
    ) u_delay (
        .clk_in    (clk_in),
        .reset     (reset),
        .load_i    (dlyLoad),
        .loadVal_i (dlyVal),
        .expired_o (dlyExpired)
    );

    // Computed one bit wider so the last entry never wraps the index
    assign idxNext = {1'b0, idx_q} + (IDX_W + 1)'(1);

    // Next-state logic for the sequencer FSM and its datapath registers
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        regData_d = regData_q;
        start_d   = 1'b0;
        errIdx_d  = errIdx_q;
        fetchPh_d = 1'b0;
        dlyLoad   = 1'b0;
        dlyVal    = '0;
`ifdef I2C_SEQ_RETRY_EN
        retryCnt_d = retryCnt_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (go) begin
                    state_d  = ST_FETCH;
                    idx_d    = '0;
                    errIdx_d = '0;
                end
            end
            ST_FETCH: begin
                if (!fetchPh_q) begin
                    fetchPh_d = 1'b1;
                end else begin
                    regData_d = rom_data;
                    state_d   = isSentinel(rom_data) ? ST_DONE : ST_ISSUE;
`ifdef I2C_SEQ_RETRY_EN
                    retryCnt_d = '0;
`endif
                end
            end
            ST_ISSUE: begin
                if (i2c_ready) begin
                    start_d = 1'b1;
                    state_d = ST_WAIT_LO;
                    dlyLoad = 1'b1;
                    dlyVal  = TIMEOUT_LOAD;
                end
            end
            ST_WAIT_LO: begin
                if (!i2c_ready) begin
                    state_d = ST_WAIT_HI;
                    dlyLoad = 1'b1;
                    dlyVal  = TIMEOUT_LOAD;
                end else if (dlyExpired) begin
                    state_d  = ST_ERROR;
                    errIdx_d = idx_q;
                end
            end
            ST_WAIT_HI: begin
                // Completion is checked before the timeout so it wins a tie
                if (i2c_ready) begin
                    if (i2c_ack) begin
                        state_d = ST_SETTLE;
                        dlyLoad = 1'b1;
                        dlyVal  = SETTLE_LOAD;
                    end else begin
`ifdef I2C_SEQ_RETRY_EN
                        if (retryCnt_q == RETRY_LIMIT) begin
                            state_d  = ST_ERROR;
                            errIdx_d = idx_q;
                        end else begin
                            retryCnt_d = retryCnt_q + 8'd1;
                            state_d    = ST_ISSUE;
                        end
`else
                        state_d  = ST_ERROR;
                        errIdx_d = idx_q;
`endif
                    end
                end else if (dlyExpired) begin
                    state_d  = ST_ERROR;
                    errIdx_d = idx_q;
                end
            end
            ST_SETTLE: begin
                if (dlyExpired) begin
                    if (idxNext == IDX_END) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idxNext[IDX_W-1:0];
                        state_d = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transfer immediately
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            regData_q <= '0;
            start_q   <= 1'b0;
            errIdx_q  <= '0;
            fetchPh_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            regData_q <= regData_d;
            start_q   <= start_d;
            errIdx_q  <= errIdx_d;
            fetchPh_q <= fetchPh_d;
        end
    end

`ifdef I2C_SEQ_RETRY_EN
    // NACK count for the entry currently being written
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            retryCnt_q <= '0;
        end else begin
            retryCnt_q <= retryCnt_d;
        end
    end
`endif

    assign rom_addr     = idx_q;
    assign i2c_start    = start_q;
    assign i2c_dev_addr = DEV_ADDR;
    assign i2c_reg_data = regData_q;
    assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERROR);
    assign done         = (state_q == ST_DONE);
    assign err          = (state_q == ST_ERROR);
    assign err_idx      = errIdx_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Self-checking bench for i2c_config_sequencer: ROM and I2C controller models
// plus a table-walk reference model; honours `define I2C_SEQ_RETRY_EN.
module tb_i2c_config_sequencer;

    localparam int NumRegs       = 3;
    localparam int SettleCycles  = 4;
    localparam int TimeoutCycles = 64;
    localparam int IdxW          = 8;
`ifdef I2C_SEQ_RETRY_EN
    localparam int RetryMax = 3;
`else
    localparam int RetryMax = 0;
`endif

    logic            clk_in    = 1'b0;
    logic            reset     = 1'b1;
    logic            go        = 1'b0;
    logic [IdxW-1:0] rom_addr;
    logic [15:0]     rom_data  = 16'h0000;
    logic            i2c_start;
    logic [7:0]      i2c_dev_addr;
    logic [15:0]     i2c_reg_data;
    logic            i2c_ready = 1'b1;
    logic            i2c_ack   = 1'b0;
    logic            busy;
    logic            done;
    logic            err;
    logic [IdxW-1:0] err_idx;
    logic [2:0]      state_dbg;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    logic [15:0] rom [0:255];
    logic [7:0]  romAddrPrev = 8'd0;

    int          ctrlPhase = 0;
    int          ctrlCnt   = 0;
    bit          stuckMode = 1'b0;
    bit          forceLong = 1'b0;
    bit          ackPlan[$];
    bit          planCopy[$];
    logic [15:0] obsWords[$];
    logic [15:0] expWords[$];
    bit          expDone;
    int          expErrIdx;
    bit          rstPrev = 1'b1;
    int          startRstViol = 0;
    int          wloCycles = 0;

    i2c_config_sequencer #(
        .NUM_REGS       (NumRegs),
        .DEV_ADDR       (8'h34),
        .SETTLE_CYCLES  (SettleCycles),
        .TIMEOUT_CYCLES (TimeoutCycles),
        .IDX_W          (IdxW)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .go           (go),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .i2c_start    (i2c_start),
        .i2c_dev_addr (i2c_dev_addr),
        .i2c_reg_data (i2c_reg_data),
        .i2c_ready    (i2c_ready),
        .i2c_ack      (i2c_ack),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .err_idx      (err_idx),
        .state_dbg    (state_dbg)
    );

    always #5 clk_in = ~clk_in;

    // ROM with one cycle of read latency: data follows the address seen a cycle earlier
    always @(negedge clk_in) begin
        rom_data    = rom[romAddrPrev];
        romAddrPrev = rom_addr;
    end

    // Behavioural I2C controller: drops ready after a start, raises it later with a planned ack
    always @(negedge clk_in) begin
        if ((reset || rstPrev) && i2c_start) startRstViol++;
        rstPrev = reset;
        if (state_dbg == 3'd3) wloCycles++;
        if (reset) begin
            i2c_ready = 1'b1;
            i2c_ack   = 1'b0;
            ctrlPhase = 0;
        end else begin
            case (ctrlPhase)
                0: begin
                    if (i2c_start) begin
                        obsWords.push_back(i2c_reg_data);
                        if (!stuckMode) begin
                            ctrlCnt   = int'($urandom_range(0, 2));
                            ctrlPhase = 1;
                        end
                    end
                end
                1: begin
                    if (ctrlCnt == 0) begin
                        i2c_ready = 1'b0;
                        ctrlCnt   = forceLong ? 20 : int'($urandom_range(0, 4));
                        ctrlPhase = 2;
                    end else begin
                        ctrlCnt--;
                    end
                end
                default: begin
                    if (ctrlCnt == 0) begin
                        i2c_ready = 1'b1;
                        i2c_ack   = (ackPlan.size() > 0) ? ackPlan.pop_front() : 1'b1;
                        ctrlPhase = 0;
                    end else begin
                        ctrlCnt--;
                    end
                end
            endcase
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: walk the table, consume one planned ack per write, stop on sentinel/end/too many NACKs
    task automatic buildExpected();
        int nacks;
        int ap;
        bit a;
        expWords.delete();
        expDone   = 1'b1;
        expErrIdx = 0;
        ap        = 0;
        for (int i = 0; i < NumRegs; i++) begin
            if (rom[i] == 16'hFFFF) return;
            nacks = 0;
            forever begin
                expWords.push_back(rom[i]);
                a = (ap < planCopy.size()) ? planCopy[ap] : 1'b1;
                ap++;
                if (a) break;
                nacks++;
                if (nacks > RetryMax) begin
                    expDone   = 1'b0;
                    expErrIdx = i;
                    return;
                end
            end
        end
    endtask

    task automatic pulseGo();
        @(negedge clk_in);
        go = 1'b1;
        @(negedge clk_in);
        go = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk_in);
            n++;
        end
        checkOutput({tag, ".idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic randomRom();
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom_range(0, 65534));
    endtask

    task automatic applyStimulus(input string tag, input bit midGo, input bit checkRestart);
        int n;
        buildExpected();
        obsWords.delete();
        pulseGo();
        if (checkRestart) begin
            checkOutput({tag, ".restartDone"}, {31'd0, done}, 32'd0);
            checkOutput({tag, ".restartBusy"}, {31'd0, busy}, 32'd1);
        end
        if (midGo) begin
            n = 0;
            while (obsWords.size() < 1 && n < 500) begin
                @(negedge clk_in);
                n++;
            end
            checkOutput({tag, ".firstWrite"}, {31'd0, (n < 500)}, 32'd1);
            pulseGo();
        end
        waitIdle(tag);
        repeat (20) @(negedge clk_in);
        checkOutput({tag, ".done"}, {31'd0, done}, {31'd0, expDone});
        checkOutput({tag, ".err"}, {31'd0, err}, {31'd0, !expDone});
        if (!expDone) checkOutput({tag, ".errIdx"}, {24'd0, err_idx}, expErrIdx);
        checkOutput({tag, ".nWrites"}, obsWords.size(), expWords.size());
        for (int i = 0; i < expWords.size() && i < obsWords.size(); i++)
            checkOutput($sformatf("%s.word%0d", tag, i), {16'd0, obsWords[i]}, {16'd0, expWords[i]});
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, ".done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, ".err"}, {31'd0, err}, 32'd0);
        checkOutput({tag, ".errIdx"}, {24'd0, err_idx}, 32'd0);
        checkOutput({tag, ".start"}, {31'd0, i2c_start}, 32'd0);
        checkOutput({tag, ".romAddr"}, {24'd0, rom_addr}, 32'd0);
        checkOutput({tag, ".regData"}, {16'd0, i2c_reg_data}, 32'd0);
        checkOutput({tag, ".state"}, {29'd0, state_dbg}, 32'd0);
    endtask

    initial begin
        int n;
        randomRom();
        repeat (3) @(negedge clk_in);
        checkAllZero("reset");
        checkOutput("devAddr", {24'd0, i2c_dev_addr}, 32'h34);
        reset = 1'b0;
        repeat (2) @(negedge clk_in);

        // Plain three-entry walk with every write acknowledged
        rom[0] = 16'h1234; rom[1] = 16'h5678; rom[2] = 16'h9ABC;
        ackPlan.delete(); planCopy.delete();
        applyStimulus("walk3", 1'b0, 1'b0);

        // Sentinel in entry 1 ends the table after one write
        randomRom();
        rom[1] = 16'hFFFF;
        applyStimulus("sentinel", 1'b0, 1'b0);

        // NACK on entry 2: twice then ack, and four in a row
        randomRom();
        ackPlan  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        planCopy = ackPlan;
        applyStimulus("nack2", 1'b0, 1'b0);
        ackPlan  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        planCopy = ackPlan;
        applyStimulus("nack4", 1'b0, 1'b0);
        ackPlan.delete(); planCopy.delete();

        // Controller never leaves idle: timeout in WAIT_LO
        stuckMode = 1'b1;
        wloCycles = 0;
        obsWords.delete();
        pulseGo();
        waitIdle("timeout");
        checkOutput("timeout.err", {31'd0, err}, 32'd1);
        checkOutput("timeout.errIdx", {24'd0, err_idx}, 32'd0);
        checkOutput("timeout.wloCycles", wloCycles, TimeoutCycles);
        checkOutput("timeout.nWrites", obsWords.size(), 32'd1);
        stuckMode = 1'b0;

        // Reset while waiting for the controller to finish, then a clean rerun
        randomRom();
        forceLong = 1'b1;
        pulseGo();
        n = 0;
        while (state_dbg != 3'd4 && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        checkOutput("midReset.reachedWaitHi", {29'd0, state_dbg}, 32'd4);
        reset = 1'b1;
        @(posedge clk_in);
        #1;
        checkAllZero("midReset");
        @(negedge clk_in);
        reset = 1'b0;
        forceLong = 1'b0;
        applyStimulus("afterReset", 1'b0, 1'b0);
        checkOutput("startDuringReset", startRstViol, 32'd0);

        // go while busy is ignored; go in DONE reruns
        randomRom();
        applyStimulus("goBusy", 1'b1, 1'b0);
        checkOutput("goBusy.doneBeforeRerun", {31'd0, done}, 32'd1);
        applyStimulus("goDone", 1'b0, 1'b1);

        // Random tables and ack patterns against the reference walk
        for (int r = 0; r < 4; r++) begin
            randomRom();
            ackPlan.delete();
            for (int k = 0; k < 8; k++) ackPlan.push_back($urandom_range(0, 3) != 0);
            planCopy = ackPlan;
            applyStimulus($sformatf("rand%0d", r), 1'b0, (r == 0) && done);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
